// File: rtl/vproc_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vproc_mem_pkg
//  Brief    : Shared types and constants for the VProc64 memory responder.
//  Revision : 1.0
// ============================================================================
package vproc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [63:0] BAD_READ_DATA = 64'hDEADBEEFDEADBEEF;
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;

  // Right-shifting Galois step: feedback bit is the outgoing LSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    lfsr_next = {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vproc_mem_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : vproc_mem_lfsr
//  Brief    : 16-bit Galois LFSR used to randomise responder wait states.
//  Revision : 1.0
// ============================================================================
module vproc_mem_lfsr
  import vproc_mem_pkg::*;
(
  input  logic        Clk,
  input  logic        nReset,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] r_value;

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      r_value <= LFSR_SEED;
    end else if (step) begin
      r_value <= lfsr_next(r_value);
    end
  end

  assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/vproc64_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : vproc64_mem_responder
//  Brief    : VProc64 bus slave backed by a 64-bit word memory with
//             programmable wait states and one-cycle registered acks.
//             Optional feature macro: VPROC_MEM_RAND_WAIT_EN (LFSR jitter).
//  Revision : 1.0
// ============================================================================
module vproc64_mem_responder
  import vproc_mem_pkg::*;
#(
  parameter int          ADDR_BITS   = 12,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int          WAIT_STATES = 0,
  parameter int          BURST_WAIT  = 0
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic [63:0] Addr,
  input  logic [7:0]  BE,
  input  logic        WE,
  input  logic        RD,
  input  logic [63:0] DataIn,
  output logic [63:0] DataOut,
  output logic        WRAck,
  output logic        RDAck,
  input  logic [11:0] Burst,
  input  logic        BurstFirst,
  input  logic        BurstLast,
  output logic        Busy,
  output logic        AddrErr
);

  localparam int          c_depth = 1 << ADDR_BITS;
  localparam logic [63:0] c_base  = BASE_ADDR;
  localparam logic [4:0]  c_wait  = 5'(WAIT_STATES);
  localparam logic [4:0]  c_bwait = 5'(BURST_WAIT);

  state_t                 r_state;
  state_t                 w_next;
  logic [4:0]             r_cnt;
  logic [ADDR_BITS-1:0]   r_idx;
  logic                   r_hit;
  logic [7:0]             r_be;
  logic [63:0]            r_wdata;
  logic                   r_we;
  logic                   r_rd;
  logic                   r_after_last;
  logic                   r_wrack;
  logic                   r_rdack;
  logic [63:0]            r_dout;
  logic                   r_err;
  logic [63:0]            r_mem [c_depth];

  logic                   w_accept;
  logic                   w_enter_ack;
  logic                   w_hit;
  logic                   w_use_burst;
  logic [4:0]             w_extra;
  logic [4:0]             w_load;

  assign w_accept    = (r_state == IDLE) && (RD || WE);
  // Every access passes through WAIT, so a zero count still costs one cycle.
  assign w_enter_ack = (r_state == WAIT) && (r_cnt == 5'd0);
  assign w_hit       = (Addr[63:ADDR_BITS] == c_base[63:ADDR_BITS]);
  assign w_use_burst = (Burst != 12'd0) && !BurstFirst && !r_after_last;

`ifdef VPROC_MEM_RAND_WAIT_EN
  logic [15:0] w_lfsr;

  vproc_mem_lfsr u_lfsr (
    .Clk    (Clk),
    .nReset (nReset),
    .step   (w_accept),
    .value  (w_lfsr)
  );

  assign w_extra = {3'b000, w_lfsr[1:0]};
`else
  assign w_extra = 5'd0;
`endif

  assign w_load = (w_use_burst ? c_bwait : c_wait) + w_extra;

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (RD || WE) w_next = WAIT;
      WAIT:    if (r_cnt == 5'd0) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture needs no reset: it is only consumed after an accept.
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_idx   <= Addr[ADDR_BITS-1:0];
      r_hit   <= w_hit;
      r_be    <= BE;
      r_wdata <= DataIn;
      r_we    <= WE;
      r_rd    <= RD;
    end
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      r_cnt        <= 5'd0;
      r_wrack      <= 1'b0;
      r_rdack      <= 1'b0;
      r_dout       <= 64'd0;
      r_err        <= 1'b0;
      r_after_last <= 1'b0;
    end else begin
      r_wrack <= 1'b0;
      r_rdack <= 1'b0;
      if (w_accept) begin
        r_cnt        <= w_load;
        r_after_last <= BurstLast;
      end else if (r_state == WAIT && r_cnt != 5'd0) begin
        r_cnt <= r_cnt - 5'd1;
      end
      if (w_enter_ack) begin
        if (r_we) begin
          r_wrack <= 1'b1;
        end else begin
          r_rdack <= 1'b1;
          r_dout  <= r_hit ? r_mem[r_idx] : BAD_READ_DATA;
        end
        if (!r_hit || (r_we && r_rd)) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (nReset && w_enter_ack && r_we && r_hit) begin
      for (int b = 0; b < 8; b++) begin
        if (r_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  assign DataOut = r_dout;
  assign WRAck   = r_wrack;
  assign RDAck   = r_rdack;
  assign Busy    = (r_state != IDLE);
  assign AddrErr = r_err;

endmodule
`default_nettype wire
